// File: rtl/lcd_seq_pkg.sv
// Shared state encoding, init nibbles and command constants for the LCD command sequencer.
package lcd_seq_pkg;

  typedef logic [4:0] state_t;

  localparam state_t PWR_WAIT = 5'd0;
  localparam state_t IE1      = 5'd1;
  localparam state_t IE2      = 5'd2;
  localparam state_t IE3      = 5'd3;
  localparam state_t IE4      = 5'd4;
  localparam state_t IW1      = 5'd5;
  localparam state_t IW2      = 5'd6;
  localparam state_t IW3      = 5'd7;
  localparam state_t IW4      = 5'd8;
  localparam state_t IDLE     = 5'd9;
  localparam state_t SU_H     = 5'd10;
  localparam state_t PE_H     = 5'd11;
  localparam state_t GAP      = 5'd12;
  localparam state_t SU_L     = 5'd13;
  localparam state_t PE_L     = 5'd14;
  localparam state_t EXEC     = 5'd15;

  // Element [k] is the nibble strobed in IE(k+1).
  localparam logic [3:0][3:0] INIT_NIBBLE = {4'd2, 4'd3, 4'd3, 4'd3};

  localparam logic [7:0] LCD_CLR  = 8'h01;
  localparam logic [7:0] LCD_HOME = 8'h02;

  // Clear/Home (and 0x03, which the controller also treats as Home) need the long execute wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLR || data == LCD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Byte command port between the display-content FSM and the LCD sequencer.
interface lcd_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_delay_timer.sv
// Down-counter for state durations: load N on entry, tick while the count is 1.
module lcd_delay_timer #(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Holds at 1 when nothing reloads it (IDLE), so it can never wrap through zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 4-bit power-on sequencer plus byte command/data writer with internal delay timing.
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 20,
  parameter int unsigned T_PWRON = 750000,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_GAP   = 50,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_INIT3 = 2000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic                      clk,
  input  logic                      reset,
  lcd_cmd_sequencer_if.slave        cmd,
  output logic                      init_done,
  output logic                      lcd_e,
  output logic                      lcd_rs,
  output logic                      lcd_rw,
  output logic [3:0]                lcd_d
);

  localparam logic [CNT_W-1:0] T_PULSE_C = CNT_W'(T_PULSE);
  localparam logic [CNT_W-1:0] T_SETUP_C = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] T_GAP_C   = CNT_W'(T_GAP);
  localparam logic [CNT_W-1:0] T_INIT1_C = CNT_W'(T_INIT1);
  localparam logic [CNT_W-1:0] T_INIT2_C = CNT_W'(T_INIT2);
  localparam logic [CNT_W-1:0] T_INIT3_C = CNT_W'(T_INIT3);
  localparam logic [CNT_W-1:0] T_CMD_C   = CNT_W'(T_CMD);
  localparam logic [CNT_W-1:0] T_CLR_C   = CNT_W'(T_CLR);
  localparam logic [CNT_W-1:0] T_PWRON_C = CNT_W'(T_PWRON);

  state_t           state_q, state_d;
  logic             rs_lat_q, rs_lat_d;
  logic [7:0]       data_lat_q, data_lat_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [3:0]       d_q, d_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tick;

  lcd_delay_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (T_PWRON)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_val   = '0;
    rs_lat_d   = rs_lat_q;
    data_lat_d = data_lat_q;
    case (state_q)
      PWR_WAIT: if (tick) begin state_d = IE1;  load = 1'b1; load_val = T_PULSE_C; end
      IE1:      if (tick) begin state_d = IW1;  load = 1'b1; load_val = T_INIT1_C; end
      IW1:      if (tick) begin state_d = IE2;  load = 1'b1; load_val = T_PULSE_C; end
      IE2:      if (tick) begin state_d = IW2;  load = 1'b1; load_val = T_INIT2_C; end
      IW2:      if (tick) begin state_d = IE3;  load = 1'b1; load_val = T_PULSE_C; end
      IE3:      if (tick) begin state_d = IW3;  load = 1'b1; load_val = T_INIT3_C; end
      IW3:      if (tick) begin state_d = IE4;  load = 1'b1; load_val = T_PULSE_C; end
      IE4:      if (tick) begin state_d = IW4;  load = 1'b1; load_val = T_INIT3_C; end
      IW4:      if (tick) state_d = IDLE;
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_d    = SU_H;
          load       = 1'b1;
          load_val   = T_SETUP_C;
          rs_lat_d   = cmd.cmd_rs;
          data_lat_d = cmd.cmd_data;
        end
      end
      SU_H:     if (tick) begin state_d = PE_H; load = 1'b1; load_val = T_PULSE_C; end
      PE_H:     if (tick) begin state_d = GAP;  load = 1'b1; load_val = T_GAP_C;   end
      GAP:      if (tick) begin state_d = SU_L; load = 1'b1; load_val = T_SETUP_C; end
      SU_L:     if (tick) begin state_d = PE_L; load = 1'b1; load_val = T_PULSE_C; end
      PE_L: begin
        if (tick) begin
          state_d  = EXEC;
          load     = 1'b1;
          load_val = is_long_cmd(rs_lat_q, data_lat_q) ? T_CLR_C : T_CMD_C;
        end
      end
      EXEC:     if (tick) state_d = IDLE;
      default: begin
        state_d  = PWR_WAIT;
        load     = 1'b1;
        load_val = T_PWRON_C;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the edge entering it.
  always_comb begin
    e_d         = 1'b0;
    rs_d        = 1'b0;
    d_d         = 4'd0;
    ready_d     = (state_d == IDLE);
    init_done_d = init_done_q | (state_d == IDLE);
    case (state_d)
      IE1:  begin e_d = 1'b1; d_d = INIT_NIBBLE[0]; end
      IE2:  begin e_d = 1'b1; d_d = INIT_NIBBLE[1]; end
      IE3:  begin e_d = 1'b1; d_d = INIT_NIBBLE[2]; end
      IE4:  begin e_d = 1'b1; d_d = INIT_NIBBLE[3]; end
      SU_H: begin rs_d = rs_lat_d; d_d = data_lat_d[7:4]; end
      PE_H: begin rs_d = rs_lat_d; d_d = data_lat_d[7:4]; e_d = 1'b1; end
      SU_L: begin rs_d = rs_lat_d; d_d = data_lat_d[3:0]; end
      PE_L: begin rs_d = rs_lat_d; d_d = data_lat_d[3:0]; e_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWR_WAIT;
      rs_lat_q    <= 1'b0;
      data_lat_q  <= 8'd0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      d_q         <= 4'd0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_lat_q    <= rs_lat_d;
      data_lat_q  <= data_lat_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      d_q         <= d_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign init_done     = init_done_q;
  assign lcd_e         = e_q;
  assign lcd_rs        = rs_q;
  assign lcd_d         = d_q;
  assign lcd_rw        = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized scoreboard bench: a timing model predicts every E strobe and cmd_ready return.
module tb_lcd_cmd_sequencer;

  localparam int T_PWRON = 10;
  localparam int T_PULSE = 3;
  localparam int T_SETUP = 2;
  localparam int T_GAP   = 4;
  localparam int T_INIT1 = 8;
  localparam int T_INIT2 = 5;
  localparam int T_INIT3 = 4;
  localparam int T_CMD   = 6;
  localparam int T_CLR   = 20;

  typedef struct {
    logic [3:0] nib;
    logic       rs;
    int         rise;
    bit         is_byte;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_cmd_sequencer_if u_if ();

  lcd_cmd_sequencer #(
    .CNT_W   (20),
    .T_PWRON (T_PWRON),
    .T_PULSE (T_PULSE),
    .T_SETUP (T_SETUP),
    .T_GAP   (T_GAP),
    .T_INIT1 (T_INIT1),
    .T_INIT2 (T_INIT2),
    .T_INIT3 (T_INIT3),
    .T_CMD   (T_CMD),
    .T_CLR   (T_CLR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (u_if.slave),
    .init_done (init_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_vec = 0;
  int     n_mis = 0;
  pulse_t pq[$];
  int     rq[$];
  int     model_ready = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Power-on timeline derived from the sequence of durations.
  task automatic push_init(input int rel);
    int     waits[4];
    int     nibs[4];
    int     t;
    pulse_t p;
    waits = '{T_INIT1, T_INIT2, T_INIT3, T_INIT3};
    nibs  = '{3, 3, 3, 2};
    t = rel + T_PWRON;
    for (int k = 0; k < 4; k++) begin
      p.nib = 4'(nibs[k]); p.rs = 1'b0; p.rise = t; p.is_byte = 1'b0;
      pq.push_back(p);
      t += T_PULSE + waits[k];
    end
    rq.push_back(t);
    model_ready = t;
  endtask

  // Called at a negedge; holds cmd_valid until the predicted accept edge has passed.
  task automatic send(input logic rs, input logic [7:0] data, output int acc);
    pulse_t p;
    int     exec_t;
    u_if.cmd_valid = 1'b1;
    u_if.cmd_rs    = rs;
    u_if.cmd_data  = data;
    acc = (cyc + 1 > model_ready + 1) ? cyc + 1 : model_ready + 1;
    exec_t = (!rs && data >= 8'd1 && data <= 8'd3) ? T_CLR : T_CMD;
    p.rs = rs; p.is_byte = 1'b1;
    p.nib = data[7:4]; p.rise = acc + T_SETUP;
    pq.push_back(p);
    p.nib = data[3:0]; p.rise = acc + 2 * T_SETUP + T_PULSE + T_GAP;
    pq.push_back(p);
    model_ready = acc + 2 * T_SETUP + 2 * T_PULSE + T_GAP + exec_t;
    rq.push_back(model_ready);
    while (cyc < acc) @(negedge clk);
    u_if.cmd_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes E or raises cmd_ready.
  initial begin
    logic       e_prev = 1'b0, rdy_prev = 1'b0, stable_bad = 1'b0;
    logic [4:0] last_bus = '0;
    int         last_change = 0, rise_cyc = 0;
    pulse_t     p;
    forever begin
      @(negedge clk);
      if (reset) begin
        e_prev = 1'b0; rdy_prev = 1'b0; last_bus = '0; last_change = cyc;
      end else begin
        logic changed;
        chk("lcd_rw", lcd_rw, 0);
        changed = ({lcd_rs, lcd_d} != last_bus);
        if (lcd_e && !e_prev) begin
          if (pq.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
          end else begin
            p = pq.pop_front();
            chk("pulse_nibble", lcd_d, p.nib);
            chk("pulse_rs", lcd_rs, p.rs);
            chk("pulse_rise_cycle", cyc, p.rise);
            if (p.is_byte) chk("setup_time_ok", (cyc - last_change) >= T_SETUP, 1);
          end
          rise_cyc = cyc; stable_bad = 1'b0;
        end else if (lcd_e && changed) begin
          stable_bad = 1'b1;
        end
        if (!lcd_e && e_prev) begin
          chk("pulse_width", cyc - rise_cyc, T_PULSE);
          chk("bus_stable_in_pulse", stable_bad, 0);
        end
        if (changed) begin
          last_bus = {lcd_rs, lcd_d}; last_change = cyc;
        end
        if (u_if.cmd_ready && !rdy_prev) begin
          if (rq.size() == 0) chk("unexpected_ready", 1, 0);
          else chk("ready_rise_cycle", cyc, rq.pop_front());
          chk("init_done_at_ready", init_done, 1);
        end
        e_prev = lcd_e; rdy_prev = u_if.cmd_ready;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc, pl;
    logic       rs;
    logic [7:0] data;
    u_if.cmd_valid = 1'b0;
    u_if.cmd_rs    = 1'b0;
    u_if.cmd_data  = 8'h00;
    #1;
    chk("reset_lcd_e", lcd_e, 0);
    chk("reset_lcd_d", lcd_d, 0);
    chk("reset_lcd_rs", lcd_rs, 0);
    chk("reset_ready", u_if.cmd_ready, 0);
    chk("reset_init_done", init_done, 0);
    repeat (3) @(posedge clk);
    #3;
    push_init(cyc);
    reset = 1'b0;

    // Offered during init: must wait for IDLE.
    @(negedge clk);
    send(1'b1, 8'h4A, acc);
    send(1'b0, 8'h01, acc);
    send(1'b1, 8'h01, acc);
    repeat (2) @(negedge clk);
    // Back-to-back: valid stays high across bytes.
    send(1'b0, 8'h02, acc);
    send(1'b1, 8'h00, acc);
    send(1'b0, 8'h38, acc);

    for (int i = 0; i < 14; i++) begin
      rs   = 1'($urandom_range(0, 1));
      data = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rs, data, acc);
    end

    // Reset while the low nibble strobe is high.
    send(1'b1, 8'h5C, acc);
    pl = acc + 2 * T_SETUP + T_PULSE + T_GAP;
    while (cyc < pl + 1) @(negedge clk);
    chk("pe_l_strobe_high", lcd_e, 1);
    #2 reset = 1'b1;
    #1;
    chk("midbyte_reset_lcd_e", lcd_e, 0);
    chk("midbyte_reset_lcd_d", lcd_d, 0);
    chk("midbyte_reset_lcd_rs", lcd_rs, 0);
    chk("midbyte_reset_ready", u_if.cmd_ready, 0);
    chk("midbyte_reset_init_done", init_done, 0);
    chk("pulses_before_reset", pq.size(), 0);
    pq.delete();
    rq.delete();
    repeat (3) @(posedge clk);
    #3;
    push_init(cyc);
    reset = 1'b0;

    @(negedge clk);
    send(1'b0, 8'h03, acc);
    while (cyc < model_ready + 8) @(negedge clk);
    chk("final_pulses_left", pq.size(), 0);
    chk("final_ready_left", rq.size(), 0);
    chk("final_ready", u_if.cmd_ready, 1);
    chk("final_init_done", init_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
